// File: rtl/rle_pkg.sv
// Shared constants and types for the RLE compressor/decompressor pair.
// A compressed pair is 16 bits: count in the low byte, value in the high byte.
package rle_pkg;

  // Decoder FSM states
  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StLatch,
    StExpand,
    StWr,
    StDone
  } rle_state_e;

  localparam int unsigned PAIR_W     = 16;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned CNT_LSB    = 0;
  localparam int unsigned VAL_LSB    = 8;
  localparam int unsigned CNT_W      = 8;

  // Encoder side: longest run a single pair can describe
  localparam int unsigned MAX_RUN    = 255;

endpackage

// File: rtl/rle_byte_packer.sv
// Accumulates bytes into a 32-bit word, little-endian (first byte in [7:0]).
// Ports:
//   clk, nreset      - clock, async active-low reset
//   push, data_byte  - append one byte
//   clear            - drop all held bytes (applied before a same-cycle push)
//   word             - current word, unfilled bytes read as 0
//   full             - 4 bytes held
//   almost_full      - 3 bytes held (next push fills the word)
//   empty            - no bytes held
module rle_byte_packer
  import rle_pkg::*;
(
  input  logic        clk,
  input  logic        nreset,
  input  logic        push,
  input  logic [7:0]  data_byte,
  input  logic        clear,
  output logic [31:0] word,
  output logic        full,
  output logic        almost_full,
  output logic        empty
);

  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;

  always_comb begin
    word_d = clear ? 32'd0 : word_q;
    cnt_d  = clear ? 3'd0 : cnt_q;
    if (push && (cnt_d != 3'(WORD_BYTES))) begin
      word_d[{cnt_d[1:0], 3'b000} +: 8] = data_byte;
      cnt_d = cnt_d + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_q  <= 3'd0;
      word_q <= 32'd0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign word        = word_q;
  assign full        = (cnt_q == 3'(WORD_BYTES));
  assign almost_full = (cnt_q == 3'(WORD_BYTES - 1));
  assign empty       = (cnt_q == 3'd0);

endmodule

// File: rtl/rle_decode.sv
// Run-length decoder: reads {value, count} byte pairs from the shared dpsram
// over port A and writes the expanded bytes back, packed little-endian.
// Ports:
//   clk, nreset           - clock, async active-low reset
//   start                 - one-cycle pulse, honoured only in IDLE/DONE
//   rle_addr, rle_size    - compressed frame location and length in bytes
//   message_addr          - destination of the expanded frame
//   message_size          - expanded bytes emitted
//   done                  - high while in DONE
//   port_A_*              - dpsram master port (read data one cycle after address)
module rle_decode
  import rle_pkg::*;
(
  input  logic        clk,
  input  logic        nreset,
  input  logic        start,
  input  logic [31:0] rle_addr,
  input  logic [31:0] rle_size,
  input  logic [31:0] message_addr,
  output logic [31:0] message_size,
  output logic        done,
  output logic        port_A_clk,
  output logic [15:0] port_A_addr,
  output logic        port_A_we,
  output logic [31:0] port_A_data_in,
  input  logic [31:0] port_A_data_out
);

  rle_state_e       state_q, state_d;
  logic [15:0]      rd_amt_q, rd_amt_d;
  logic [15:0]      wr_amt_q, wr_amt_d;
  logic [31:0]      msg_size_q, msg_size_d;
  logic [31:0]      word_q, word_d;
  logic             pair_sel_q, pair_sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q;

  logic             pk_push, pk_clear, pk_full, pk_almost_full, pk_empty;
  logic [31:0]      pk_word;
  logic [7:0]       cur_val, pair1_cnt;
  logic             more_words, pair1_valid, next_pair;
  logic [15:0]      rd_addr, wr_addr;
  logic             unused_bits;

  assign cur_val   = pair_sel_q ? word_q[PAIR_W + VAL_LSB +: 8] : word_q[VAL_LSB +: 8];
  assign pair1_cnt = word_q[PAIR_W + CNT_LSB +: 8];

  // rd_amt has already advanced past the current word once it is latched
  assign more_words  = ({16'd0, rd_amt_q} < rle_size);
  // Pair 1 of the final word is padding when the frame ends on a half word
  assign pair1_valid = !(rle_size[1] && !more_words);
  assign next_pair   = !pair_sel_q && pair1_valid;

  assign rd_addr = rle_addr[15:0] + rd_amt_q;
  assign wr_addr = message_addr[15:0] + wr_amt_q;

  assign unused_bits = ^{rle_addr[31:16], message_addr[31:16], pk_full};

  rle_byte_packer u_packer (
    .clk         (clk),
    .nreset      (nreset),
    .push        (pk_push),
    .data_byte   (cur_val),
    .clear       (pk_clear),
    .word        (pk_word),
    .full        (pk_full),
    .almost_full (pk_almost_full),
    .empty       (pk_empty)
  );

  always_comb begin
    state_d    = state_q;
    rd_amt_d   = rd_amt_q;
    wr_amt_d   = wr_amt_q;
    msg_size_d = msg_size_q;
    word_d     = word_q;
    pair_sel_d = pair_sel_q;
    cnt_d      = cnt_q;
    pk_push    = 1'b0;
    pk_clear   = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          rd_amt_d   = 16'd0;
          wr_amt_d   = 16'd0;
          msg_size_d = 32'd0;
          word_d     = 32'd0;
          pair_sel_d = 1'b0;
          cnt_d      = '0;
          pk_clear   = 1'b1;
          state_d    = (rle_size == 32'd0) ? StDone : StRd;
        end
      end
      StRd: state_d = StLatch;
      StLatch: begin
        word_d     = port_A_data_out;
        rd_amt_d   = rd_amt_q + 16'(WORD_BYTES);
        pair_sel_d = 1'b0;
        cnt_d      = port_A_data_out[CNT_LSB +: CNT_W];
        state_d    = StExpand;
      end
      StExpand: begin
        if (cnt_q != '0) begin
          pk_push    = 1'b1;
          cnt_d      = cnt_q - 8'd1;
          msg_size_d = msg_size_q + 32'd1;
          // Decide the exhaustion step on the last byte so a run ending
          // a word costs no idle cycle; a filled word still wins.
          if (pk_almost_full) begin
            state_d = StWr;
          end else if (cnt_q == 8'd1) begin
            if (next_pair) begin
              pair_sel_d = 1'b1;
              cnt_d      = pair1_cnt;
            end else if (more_words) begin
              state_d = StRd;
            end else begin
              state_d = StWr;
            end
          end
        end else if (next_pair) begin
          pair_sel_d = 1'b1;
          cnt_d      = pair1_cnt;
        end else if (more_words) begin
          state_d = StRd;
        end else if (!pk_empty) begin
          state_d = StWr;
        end else begin
          state_d = StDone;
        end
      end
      StWr: begin
        pk_clear = 1'b1;
        wr_amt_d = wr_amt_q + 16'(WORD_BYTES);
        if ((cnt_q != '0) || next_pair) begin
          state_d = StExpand;
        end else if (more_words) begin
          state_d = StRd;
        end else begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= StIdle;
      rd_amt_q   <= 16'd0;
      wr_amt_q   <= 16'd0;
      msg_size_q <= 32'd0;
      word_q     <= 32'd0;
      pair_sel_q <= 1'b0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_amt_q   <= rd_amt_d;
      wr_amt_q   <= wr_amt_d;
      msg_size_q <= msg_size_d;
      word_q     <= word_d;
      pair_sel_q <= pair_sel_d;
      cnt_q      <= cnt_d;
      done_q     <= (state_d == StDone);
    end
  end

  always_comb begin
    port_A_addr    = 16'd0;
    port_A_we      = 1'b0;
    port_A_data_in = 32'd0;
    case (state_q)
      StRd, StLatch: port_A_addr = rd_addr;
      StWr: begin
        port_A_addr    = wr_addr;
        port_A_we      = 1'b1;
        port_A_data_in = pk_word;
      end
      default: ;
    endcase
  end

  assign port_A_clk   = clk;
  assign message_size = msg_size_q;
  assign done         = done_q;

endmodule
